// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, size and legality decode.
// Misaligned-access trapping is selected at build time with LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_e;

  // Access size in bytes; 0 marks an encoding with no defined size.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = 3'd1;
      F3_H, F3_HU: f3_size = 3'd2;
      F3_W:        f3_size = 3'd4;
      default:     f3_size = 3'd0;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    f3_legal = (f3_size(f3) != 3'd0);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3_size(f3))
      3'd2:    misaligned = off[0];
      3'd4:    misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte masks and shifted store data for both halves, plus load
// extract/extend from the {hi,lo} word pair; purely combinational, no backpressure.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic        split_o,
  output logic [3:0]  wen0_o,
  output logic [3:0]  wen1_o,
  output logic [31:0] wdat0_o,
  output logic [31:0] wdat1_o,
  output logic [31:0] rdata_o
);

  logic [2:0]  size;
  logic [3:0]  mask;
  logic [7:0]  mask_sh;
  logic [63:0] wsh;
  logic [31:0] ext;

  assign size = f3_size(funct3_i);

  always_comb begin
    mask = 4'b0000;
    case (size)
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      3'd4:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

  assign split_o = ({2'b00, off_i} + {1'b0, size}) > 4'd4;

  // Shifting into a double-width word yields both halves at once: the upper half is what
  // spills into the next word.
  assign mask_sh = {4'b0000, mask} << off_i;
  assign wsh     = {32'b0, wdata_i} << {off_i, 3'b000};
  assign wen0_o  = mask_sh[3:0];
  assign wen1_o  = mask_sh[7:4];
  assign wdat0_o = wsh[31:0];
  assign wdat1_o = wsh[63:32];

  assign ext = 32'({hi_i, lo_i} >> {off_i, 3'b000});

  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{ext[7]}}, ext[7:0]};
      F3_H:    rdata_o = {{16{ext[15]}}, ext[15:0]};
      F3_W:    rdata_o = ext;
      F3_BU:   rdata_o = {24'b0, ext[7:0]};
      F3_HU:   rdata_o = {16'b0, ext[15:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store initiator: latency 2 (aligned), 3 (word-crossing split), 1 (error); req_ready only
// in IDLE, response held until resp_ready. LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [3:0]        dm_w_en,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_write_data,
  input  logic [DATA_W-1:0] dm_read_data
);

  state_e            state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] lo_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [3:0]        dm_w_en_q;
  logic [ADDR_W-1:0] dm_address_q;
  logic [DATA_W-1:0] dm_write_data_q;

  logic [2:0]        al_f3;
  logic [1:0]        al_off;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_lo;
  logic              al_split;
  logic [3:0]        al_wen0;
  logic [3:0]        al_wen1;
  logic [DATA_W-1:0] al_wdat0;
  logic [DATA_W-1:0] al_wdat1;
  logic [DATA_W-1:0] al_rdata;
  logic              bad_req;
  logic [ADDR_W-1:0] base_addr;

  // In IDLE the lane logic looks at the incoming request so ACC0 outputs can be registered at accept.
  always_comb begin
    al_f3    = f3_q;
    al_off   = addr_q[1:0];
    al_wdata = wdata_q;
    if (state_q == IDLE) begin
      al_f3    = req_funct3;
      al_off   = req_addr[1:0];
      al_wdata = req_wdata;
    end
  end

  assign al_lo     = (state_q == ACC0) ? dm_read_data : lo_q;
  assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_req = !f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
  assign bad_req = !f3_legal(req_we, req_funct3);
`endif

  lsu_align u_align (
    .funct3_i (al_f3),
    .off_i    (al_off),
    .wdata_i  (al_wdata),
    .lo_i     (al_lo),
    .hi_i     (dm_read_data),
    .split_o  (al_split),
    .wen0_o   (al_wen0),
    .wen1_o   (al_wen1),
    .wdat0_o  (al_wdat0),
    .wdat1_o  (al_wdat1),
    .rdata_o  (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      f3_q            <= 3'b000;
      addr_q          <= '0;
      wdata_q         <= '0;
      lo_q            <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= '0;
      dm_w_en_q       <= 4'b0000;
      dm_address_q    <= '0;
      dm_write_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            f3_q        <= req_funct3;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (bad_req) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q         <= ACC0;
              dm_address_q    <= {req_addr[ADDR_W-1:2], 2'b00};
              dm_w_en_q       <= req_we ? al_wen0 : 4'b0000;
              dm_write_data_q <= req_we ? al_wdat0 : '0;
            end
          end
        end
        ACC0: begin
          lo_q <= dm_read_data;
          if (al_split) begin
            state_q         <= ACC1;
            dm_address_q    <= base_addr + ADDR_W'(4);
            dm_w_en_q       <= we_q ? al_wen1 : 4'b0000;
            dm_write_data_q <= we_q ? al_wdat1 : '0;
          end else begin
            state_q         <= RESP;
            dm_address_q    <= '0;
            dm_w_en_q       <= 4'b0000;
            dm_write_data_q <= '0;
            resp_valid_q    <= 1'b1;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= we_q ? '0 : al_rdata;
          end
        end
        ACC1: begin
          state_q         <= RESP;
          dm_address_q    <= '0;
          dm_w_en_q       <= 4'b0000;
          dm_write_data_q <= '0;
          resp_valid_q    <= 1'b1;
          resp_err_q      <= 1'b0;
          resp_rdata_q    <= we_q ? '0 : al_rdata;
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign dm_w_en       = dm_w_en_q;
  assign dm_address    = dm_address_q;
  assign dm_write_data = dm_write_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed requests push expected responses and DM writes;
// a negedge monitor pops and compares them, including accept-to-valid latency.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [15:0] req_addr = 16'h0000;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  dm_w_en;
  logic [15:0] dm_address;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dm_w_en      (dm_w_en),
    .dm_address   (dm_address),
    .dm_write_data(dm_write_data),
    .dm_read_data (dm_read_data)
  );

  // Data memory model: combinational read, byte-lane write on the clock edge.
  logic [31:0] dmem [0:16383];
  assign dm_read_data = dmem[dm_address[15:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dm_w_en[b]) dmem[dm_address[15:2]][8*b +: 8] <= dm_write_data[8*b +: 8];
  end

  typedef struct { logic [31:0] rdata; logic err; int lat; } rsp_t;
  typedef struct { logic [15:0] addr; logic [3:0] wen; logic [31:0] dat; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t mon_r;
  wr_t  mon_w;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  logic pending = 1'b0;
  logic seen = 1'b0;
  int   lat = 0;
  int   lat_at = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (dm_w_en != 4'b0000) begin
      chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        mon_w = wr_q.pop_front();
        chk("wr_addr", 32'(dm_address), 32'(mon_w.addr));
        chk("wr_en", 32'(dm_w_en), 32'(mon_w.wen));
        chk("wr_data", dm_write_data, mon_w.dat);
      end
    end
    if (rst) begin
      pending = 1'b0;
      seen    = 1'b0;
    end else begin
      if (pending) lat++;
      if (resp_valid && !seen) begin
        seen   = 1'b1;
        lat_at = lat;
      end
      if (resp_valid && resp_ready) begin
        chk("resp_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          mon_r = rsp_q.pop_front();
          chk("resp_rdata", resp_rdata, mon_r.rdata);
          chk("resp_err", 32'(resp_err), 32'(mon_r.err));
          chk("resp_latency", 32'(lat_at), 32'(mon_r.lat));
        end
        pending = 1'b0;
        seen    = 1'b0;
      end
      if (req_valid && req_ready) begin
        pending = 1'b1;
        lat     = 0;
        seen    = 1'b0;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                       input logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("resp_drain", 32'(rsp_q.size()), 32'd0);
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el);
    rsp_q.push_back('{rdata: er, err: ee, lat: el});
    issue(we, f3, addr, wd);
    drain();
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d);
    wr_q.push_back('{addr: a, wen: w, dat: d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  rf3;
    logic [31:0] rwd;
    int n;
    for (int i = 0; i < 16384; i++) dmem[i] = 32'h0;
    dmem[14'h0040] = 32'h8899AABB;
    dmem[14'h0080] = 32'h44332211;
    dmem[14'h0081] = 32'h88776655;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_dm_w_en", 32'(dm_w_en), 32'd0);
    chk("rst_dm_address", 32'(dm_address), 32'd0);
    chk("rst_dm_write_data", dm_write_data, 32'd0);

    do_req(1'b0, 3'b000, 16'h0101, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
    do_req(1'b0, 3'b100, 16'h0101, 32'h0, 32'h000000AA, 1'b0, 2);
    push_wr(16'h0100, 4'b1100, 32'h12340000);
    do_req(1'b1, 3'b001, 16'h0102, 32'h00001234, 32'h0, 1'b0, 2);
    do_req(1'b0, 3'b010, 16'h0100, 32'h0, 32'h1234AABB, 1'b0, 2);
    do_req(1'b0, 3'b001, 16'h0206, 32'h0, 32'hFFFF8877, 1'b0, 2);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 3'b010, 16'h0203, 32'h0, 32'h0, 1'b1, 1);
    do_req(1'b0, 3'b101, 16'h0203, 32'h0, 32'h0, 1'b1, 1);
    do_req(1'b1, 3'b010, 16'hFFFE, 32'hDEADBEEF, 32'h0, 1'b1, 1);
    do_req(1'b0, 3'b010, 16'h0000, 32'h0, 32'h0, 1'b0, 2);
`else
    do_req(1'b0, 3'b010, 16'h0203, 32'h0, 32'h77665544, 1'b0, 3);
    do_req(1'b0, 3'b001, 16'h0203, 32'h0, 32'h00005544, 1'b0, 3);
    push_wr(16'hFFFC, 4'b1100, 32'hBEEF0000);
    push_wr(16'h0000, 4'b0011, 32'h0000DEAD);
    do_req(1'b1, 3'b010, 16'hFFFE, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    do_req(1'b0, 3'b010, 16'hFFFE, 32'h0, 32'hDEADBEEF, 1'b0, 3);
`endif
    do_req(1'b0, 3'b011, 16'h0100, 32'h0, 32'h0, 1'b1, 1);
    do_req(1'b1, 3'b100, 16'h0100, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    do_req(1'b1, 3'b101, 16'h0100, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    do_req(1'b0, 3'b010, 16'h0100, 32'h0, 32'h1234AABB, 1'b0, 2);

    // Response held off for five cycles.
    rsp_q.push_back('{rdata: 32'h000000BB, err: 1'b0, lat: 2});
    resp_ready = 1'b0;
    issue(1'b0, 3'b100, 16'h0100, 32'h0);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, 32'h000000BB);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    drain();

    // Reset lands on the edge that ends ACC0: the ACC0 lanes commit, the second half never issues.
`ifdef LSU_MISALIGN_TRAP_EN
    rf3 = 3'b001;
    rwd = 32'h0000F00D;
`else
    rf3 = 3'b010;
    rwd = 32'hCAFEF00D;
`endif
    push_wr(16'h0300, 4'b1100, 32'hF00D0000);
    issue(1'b1, rf3, 16'h0302, rwd);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_dm_w_en", 32'(dm_w_en), 32'd0);
    repeat (5) @(negedge clk);
    chk("midrst_wr_left", 32'(wr_q.size()), 32'd0);
    do_req(1'b0, 3'b010, 16'h0300, 32'h0, 32'hF00D0000, 1'b0, 2);
    do_req(1'b0, 3'b010, 16'h0304, 32'h0, 32'h00000000, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("end_wr_q_empty", 32'(wr_q.size()), 32'd0);
    chk("end_rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
